// File: rtl/glitch_sequencer.sv
// Triggered glitch pulse sequencer: edge trigger, programmable delay and width.
// Define GLITCH_SEQ_BURST_EN for multi-pulse bursts separated by gap cycles.
module glitch_sequencer #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_in,
    input  logic               trig_pol,
    input  logic [DELAY_W-1:0] delay,
    input  logic [WIDTH_W-1:0] width,
    input  logic [7:0]         burst_n,
    input  logic [WIDTH_W-1:0] gap,
    output logic               glitch_out,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3,
`ifdef GLITCH_SEQ_BURST_EN
        DONE  = 3'd4,
        GAP   = 3'd5
`else
        DONE  = 3'd4
`endif
    } state_t;

    state_t state, state_nxt;

    logic               trig_prev;
    logic               pol_q;
    logic [DELAY_W-1:0] d_q;
    logic [WIDTH_W-1:0] w_q;
    logic [DELAY_W-1:0] dcnt;
    logic [WIDTH_W-1:0] wcnt;
    logic               det;
    logic               accept;
    logic               glitch_d, armed_d, busy_d, done_d, err_d;

`ifdef GLITCH_SEQ_BURST_EN
    logic [7:0]         n_q;
    logic [7:0]         pcnt;
    logic [WIDTH_W-1:0] g_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{burst_n, gap};
`endif

    always_comb begin
        state_nxt = state;
        det       = pol_q ? (trig_prev & ~trig_in) : (~trig_prev & trig_in);
        accept    = arm && (width != '0);
        unique case (state)
            IDLE:  if (accept) state_nxt = ARMED;
            ARMED: if (det) state_nxt = (d_q == '0) ? PULSE : DELAY;
            DELAY: if (dcnt == d_q - DELAY_W'(1)) state_nxt = PULSE;
            PULSE: begin
                if (wcnt == w_q - WIDTH_W'(1)) begin
`ifdef GLITCH_SEQ_BURST_EN
                    state_nxt = (pcnt == n_q - 8'd1) ? DONE : GAP;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef GLITCH_SEQ_BURST_EN
            GAP:   if (wcnt == g_q - WIDTH_W'(1)) state_nxt = PULSE;
`endif
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;

        // Outputs are registered decodes of the current state; abort clears them at once
        glitch_d = (state == PULSE) && !abort;
        armed_d  = (state == ARMED) && !abort;
        busy_d   = (state != IDLE) && !abort;
        done_d   = (state == DONE) && !abort;
        err_d    = (state == IDLE) && arm && (width == '0) && !abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trig_prev  <= 1'b0;
            pol_q      <= 1'b0;
            d_q        <= '0;
            w_q        <= '0;
            dcnt       <= '0;
            wcnt       <= '0;
            glitch_out <= 1'b0;
            armed      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef GLITCH_SEQ_BURST_EN
            n_q        <= '0;
            g_q        <= '0;
            pcnt       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            trig_prev  <= trig_in;
            glitch_out <= glitch_d;
            armed      <= armed_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;

            if (state == IDLE && state_nxt == ARMED) begin
                pol_q <= trig_pol;
                d_q   <= delay;
                w_q   <= width;
`ifdef GLITCH_SEQ_BURST_EN
                n_q   <= (burst_n == '0) ? 8'd1 : burst_n;
                g_q   <= (gap == '0) ? WIDTH_W'(1) : gap;
`endif
            end

            dcnt <= (state == DELAY && state_nxt == DELAY) ?
                    dcnt + DELAY_W'(1) : '0;

`ifdef GLITCH_SEQ_BURST_EN
            wcnt <= ((state == PULSE || state == GAP) && state_nxt == state) ?
                    wcnt + WIDTH_W'(1) : '0;
            if (state == ARMED)
                pcnt <= '0;
            else if (state == PULSE && state_nxt == GAP)
                pcnt <= pcnt + 8'd1;
`else
            wcnt <= (state == PULSE && state_nxt == PULSE) ?
                    wcnt + WIDTH_W'(1) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: trigger timing, abort, reset, errors.
// Edge indices count from the trigger detection edge (index 0).
module tb_glitch_sequencer;

    logic        clk = 1'b0;
    logic        rst, arm, abort, trig_in, trig_pol;
    logic [15:0] delay;
    logic [7:0]  width, burst_n, gap;
    logic        glitch_out, armed, busy, done, err;

    int errors = 0;
    int checks = 0;
    int first_g, last_g, n_g, first_d, n_d;

    always #5 clk = ~clk;

    glitch_sequencer #(.DELAY_W(16), .WIDTH_W(8)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .trig_in(trig_in), .trig_pol(trig_pol), .delay(delay),
        .width(width), .burst_n(burst_n), .gap(gap),
        .glitch_out(glitch_out), .armed(armed), .busy(busy),
        .done(done), .err(err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges; index 0 is the first edge after the call
    task automatic measure(input int n);
        first_g = -1; last_g = -1; n_g = 0;
        first_d = -1; n_d = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (glitch_out) begin
                if (first_g < 0) first_g = i;
                last_g = i;
                n_g++;
            end
            if (done) begin
                if (first_d < 0) first_d = i;
                n_d++;
            end
        end
    endtask

    task automatic arm_it(input logic pol, input int d, input int w);
        trig_pol = pol;
        delay    = 16'(d);
        width    = 8'(w);
        arm      = 1'b1;
        tick();
        arm      = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
        trig_pol = 1'b0; delay = '0; width = '0; burst_n = '0; gap = '0;
        tick();
        tick();
        chk("rst_glitch", int'(glitch_out), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        tick();

        // D=0 W=1 rising edge
        arm_it(1'b0, 0, 1);
        chk("t1_armed", int'(armed), 1);
        chk("t1_busy", int'(busy), 1);
        trig_in = 1'b1;
        measure(5);
        chk("t1_first", first_g, 1);
        chk("t1_count", n_g, 1);
        chk("t1_done", first_d, 2);
        chk("t1_ndone", n_d, 1);
        chk("t1_busy_end", int'(busy), 0);

        // D=10 W=3 falling edge, config changes after arm ignored
        trig_in = 1'b0;
        tick();
        arm_it(1'b1, 10, 3);
        width = 8'd7;
        delay = 16'd2;
        trig_in = 1'b1;
        tick();
        tick();
        chk("t2_rise_nop", int'(glitch_out), 0);
        chk("t2_still_armed", int'(armed), 1);
        trig_in = 1'b0;
        measure(20);
        chk("t2_first", first_g, 11);
        chk("t2_last", last_g, 13);
        chk("t2_count", n_g, 3);
        chk("t2_done", first_d, 14);

        // abort during second cycle of a W=5 pulse
        arm_it(1'b0, 0, 5);
        trig_in = 1'b1;
        tick();
        tick();
        tick();
        chk("t3_mid_pulse", int'(glitch_out), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_ab_glitch", int'(glitch_out), 0);
        chk("t3_ab_busy", int'(busy), 0);
        measure(8);
        chk("t3_no_done", n_d, 0);
        chk("t3_no_pulse", n_g, 0);
        trig_in = 1'b0;
        arm_it(1'b0, 0, 5);
        chk("t3_rearm", int'(armed), 1);
        abort = 1'b1;
        arm = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        tick();
        chk("t3_abort_idle", int'(armed), 0);
        chk("t3_abort_wins", int'(busy), 0);

        // width=0 rejected, idle trigger ignored, arm in DELAY ignored
        width = 8'd0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t4_err", int'(err), 1);
        chk("t4_not_armed", int'(armed), 0);
        tick();
        chk("t4_err_once", int'(err), 0);
        chk("t4_armed_low", int'(armed), 0);
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        measure(6);
        chk("t4_idle_trig", n_g, 0);
        arm_it(1'b0, 5, 2);
        trig_in = 1'b1;
        tick();
        tick();
        arm = 1'b1;
        delay = 16'd0;
        width = 8'd4;
        tick();
        arm = 1'b0;
        measure(10);
        chk("t4_first", first_g, 3);
        chk("t4_count", n_g, 2);
        chk("t4_done", first_d, 5);

        // reset mid-DELAY
        trig_in = 1'b0;
        tick();
        arm_it(1'b0, 100, 2);
        trig_in = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("t5_glitch", int'(glitch_out), 0);
        chk("t5_armed", int'(armed), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        rst = 1'b0;
        trig_in = 1'b0;
        measure(120);
        chk("t5_no_pulse", n_g, 0);
        chk("t5_no_done", n_d, 0);
        arm_it(1'b0, 3, 2);
        trig_in = 1'b1;
        measure(10);
        chk("t5_re_first", first_g, 4);
        chk("t5_re_count", n_g, 2);
        chk("t5_re_done", first_d, 6);

        // burst config: three pulses with burst enabled, one without
        trig_in = 1'b0;
        burst_n = 8'd3;
        gap = 8'd4;
        tick();
        arm_it(1'b0, 0, 2);
        trig_in = 1'b1;
        measure(20);
        chk("t6_first", first_g, 1);
`ifdef GLITCH_SEQ_BURST_EN
        chk("t6_last", last_g, 14);
        chk("t6_count", n_g, 6);
        chk("t6_done", first_d, 15);
`else
        chk("t6_last", last_g, 2);
        chk("t6_count", n_g, 2);
        chk("t6_done", first_d, 3);
`endif
        burst_n = 8'd0;
        gap = 8'd0;

        // maximum delay honoured exactly
        trig_in = 1'b0;
        tick();
        arm_it(1'b0, 65535, 1);
        trig_in = 1'b1;
        measure(65540);
        chk("t7_first", first_g, 65536);
        chk("t7_count", n_g, 1);
        chk("t7_done", first_d, 65537);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter DELAY_W, default 16, width of trigger-to-glitch delay in cycles.
REQ-002 SHALL have parameter WIDTH_W, default 8, width of the pulse-width and gap fields.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port arm  in  1  request to latch config and arm; honoured only in IDLE.
REQ-006 SHALL have port abort  in  1  cancel any activity, return to IDLE.
REQ-007 SHALL have port trig_in  in  1  external trigger, already synchronous to clk.
REQ-008 SHALL have port trig_pol  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-009 SHALL have port delay  in  DELAY_W  cycles from trigger detection to first pulse.
REQ-010 SHALL have port width  in  WIDTH_W  glitch pulse high time in cycles.
REQ-011 SHALL have port burst_n  in  8  pulses per trigger (burst builds only).
REQ-012 SHALL have port gap  in  WIDTH_W  low cycles between burst pulses (burst builds only).
REQ-013 SHALL have port glitch_out  out  1  glitch drive, flop output.
REQ-014 SHALL have port armed  out  1  high while waiting for a trigger.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-016 SHALL have port done  out  1  one-cycle pulse after the last glitch pulse ends.
REQ-017 SHALL have port err  out  1  one-cycle pulse when arm is rejected because width == 0.

Function
REQ-018 SHALL implement states IDLE, ARMED, DELAY, PULSE, GAP, DONE.
REQ-019 In IDLE, arm with width != 0 SHALL latch trig_pol/delay/width/burst_n/gap and enter ARMED next cycle; config changes afterwards are ignored until the next IDLE.
REQ-020 In IDLE, arm with width == 0 SHALL pulse err for one cycle and remain in IDLE.
REQ-021 arm outside IDLE SHALL be ignored; trigger edges outside ARMED SHALL be ignored.
REQ-022 Edge detection: trig_prev SHALL register trig_in every cycle; a trigger is detected at edge k when trig_in(k) and trig_prev show a 0->1 transition (pol 0) or a 1->0 transition (pol 1).
REQ-023 After detection at edge k in ARMED with latched delay D, glitch_out SHALL be high from edge k+1+D for exactly W cycles; D = 0 bypasses the DELAY state.
REQ-024 glitch_out SHALL be a registered state decode with no combinational path from any input.
REQ-025 After the final pulse, the sequencer SHALL spend one cycle in DONE (done = 1) and then return to IDLE.
REQ-026 The delay counter SHALL be DELAY_W bits and the width/gap counters WIDTH_W bits; counts compare against latched values and SHALL NOT wrap; D = 2^DELAY_W-1 SHALL be honoured exactly.
REQ-027 armed SHALL be high only in ARMED; busy SHALL be high in ARMED, DELAY, PULSE, GAP and DONE.
REQ-028 abort SHALL move any state to IDLE at the next edge: glitch_out, armed, busy = 0 and no done pulse; if abort and arm arrive in the same cycle in IDLE, abort wins.

Reset
REQ-029 rst SHALL force state IDLE, trig_prev = 0, all counters = 0, and glitch_out, armed, busy, done, err = 0 at the next edge.
REQ-030 rst SHALL take priority over abort and arm and over any state, including mid-pulse; glitch_out SHALL be low the cycle after rst is sampled.

Configuration
REQ-031 Macro GLITCH_SEQ_BURST_EN defined: the block SHALL emit max(burst_n,1) pulses per trigger, each W cycles high, separated by max(gap,1) low cycles in GAP.
REQ-032 Macro GLITCH_SEQ_BURST_EN undefined: the block SHALL emit exactly one pulse per trigger; burst_n and gap SHALL be ignored and the GAP state SHALL NOT be built; ports SHALL be unchanged.

Verification
REQ-033 Arm with D=0, W=1, pol 0; trig_in rises, detected at edge k -> glitch_out high only at k+1, done at k+2, busy low at k+3.
REQ-034 Arm with D=10, W=3, pol 1; trig_in falls, detected at edge k -> glitch_out high at k+11..k+13, done at k+14; the earlier rising edge causes no pulse.
REQ-035 With GLITCH_SEQ_BURST_EN: D=0, W=2, burst_n=3, gap=4, detection at edge k -> high at k+1..2, k+7..8, k+13..14; done at k+15.
REQ-036 abort asserted during the 2nd cycle of a W=5 pulse -> glitch_out low next edge, no done, next arm accepted.
REQ-037 Arm with width=0 -> err for 1 cycle, armed stays 0; trigger edge while IDLE -> no pulse; arm while in DELAY -> ignored.
REQ-038 rst asserted mid-DELAY with D=100 -> all outputs 0 next edge, no pulse after release, re-arm works normally.
